// File: rtl/ofs_plat_compat_avalon_mem_rd_throttle.sv
// Per-bank request stage between the compat AFU local-memory master and the
// PIM bank port. A 2-entry request buffer with registered waitrequest feeds
// the bank; reads at the buffer head are held back while the beats they would
// add could overrun the response buffering below. Read responses are
// registered one clock, and Avalon burst-protocol violations set a sticky flag.
//
// Burst FSM
//   state    | meaning
//   IDLE     | next accepted AFU beat is a start of packet
//   WR_BURST | inside a multi-beat write burst, beatsLeft beats still expected

module ofs_plat_compat_avalon_mem_rd_throttle #(
    parameter int ADDR_WIDTH      = 27,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int MAX_RD_BEATS    = 256,
    localparam int BE_WIDTH       = DATA_WIDTH / 8,
    localparam int PEND_WIDTH     = $clog2(MAX_RD_BEATS + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,

    input  logic [ADDR_WIDTH-1:0]      afu_address,
    input  logic                       afu_read,
    input  logic                       afu_write,
    input  logic [BURST_CNT_WIDTH-1:0] afu_burstcount,
    input  logic [DATA_WIDTH-1:0]      afu_writedata,
    input  logic [BE_WIDTH-1:0]        afu_byteenable,
    output logic                       afu_waitrequest,
    output logic [DATA_WIDTH-1:0]      afu_readdata,
    output logic                       afu_readdatavalid,

    output logic [ADDR_WIDTH-1:0]      mem_address,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [BURST_CNT_WIDTH-1:0] mem_burstcount,
    output logic [DATA_WIDTH-1:0]      mem_writedata,
    output logic [BE_WIDTH-1:0]        mem_byteenable,
    input  logic                       mem_waitrequest,
    input  logic [DATA_WIDTH-1:0]      mem_readdata,
    input  logic                       mem_readdatavalid,

    output logic [PEND_WIDTH-1:0]      rd_beats_pending,
    output logic                       err_protocol
);

    typedef struct packed {
        logic                       read;
        logic                       write;
        logic [ADDR_WIDTH-1:0]      address;
        logic [BURST_CNT_WIDTH-1:0] burstcount;
        logic [DATA_WIDTH-1:0]      writedata;
        logic [BE_WIDTH-1:0]        byteenable;
    } reqT;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WR_BURST = 1'b1
    } burstStateT;

    localparam logic [PEND_WIDTH:0] MAX_PEND = (PEND_WIDTH + 1)'(MAX_RD_BEATS);

    reqT                        slot [2];
    reqT                        head;
    reqT                        incoming;
    logic                       wrPtr;
    logic                       rdPtr;
    logic [1:0]                 count;
    logic [1:0]                 countNext;
    logic                       accept;
    logic                       pop;
    logic                       headValid;

    logic [PEND_WIDTH:0]        headBeats;
    logic [PEND_WIDTH:0]        pendWithHead;
    logic [PEND_WIDTH:0]        pendSum;
    logic [PEND_WIDTH-1:0]      pendNext;
    logic                       pendUnderflow;
    logic                       rdFits;
    logic                       issueOk;
    logic                       rdIssue;

    burstStateT                 state;
    burstStateT                 stateNext;
    logic [BURST_CNT_WIDTH-1:0] beatsLeft;
    logic [BURST_CNT_WIDTH-1:0] beatsLeftNext;
    logic                       burstErr;

    assign accept    = (afu_read || afu_write) && !afu_waitrequest;
    assign pop       = (mem_read || mem_write) && !mem_waitrequest;
    assign headValid = (count != 2'd0);
    assign head      = slot[rdPtr];
    assign incoming  = '{afu_read, afu_write, afu_address, afu_burstcount,
                         afu_writedata, afu_byteenable};

    // Occupancy after this cycle's accept and drain
    always_comb begin
        countNext = count;
        if (accept && !pop) begin
            countNext = count + 2'd1;
        end else if (pop && !accept) begin
            countNext = count - 2'd1;
        end
    end

    // Request buffer storage, pointers and registered waitrequest
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot[0]         <= '0;
            slot[1]         <= '0;
            wrPtr           <= 1'b0;
            rdPtr           <= 1'b0;
            count           <= 2'd0;
            afu_waitrequest <= 1'b1;
        end else begin
            if (accept) begin
                slot[wrPtr] <= incoming;
                wrPtr       <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            count           <= countNext;
            afu_waitrequest <= (countNext == 2'd2);
        end
    end

    // A head read may issue only if its whole burst fits under the beat cap.
    assign headBeats    = {{(PEND_WIDTH + 1 - BURST_CNT_WIDTH){1'b0}}, head.burstcount};
    assign pendWithHead = {1'b0, rd_beats_pending} + headBeats;
    assign rdFits       = (pendWithHead <= MAX_PEND);
    assign issueOk      = !head.read || rdFits;

    assign mem_read       = headValid && head.read && issueOk;
    assign mem_write      = headValid && head.write && issueOk;
    assign mem_address    = head.address;
    assign mem_burstcount = head.burstcount;
    assign mem_writedata  = head.writedata;
    assign mem_byteenable = head.byteenable;
    assign rdIssue        = mem_read && !mem_waitrequest;

    // Outstanding read beats: add the issued burst, retire one per response
    always_comb begin
        pendSum       = {1'b0, rd_beats_pending} + (rdIssue ? headBeats : '0);
        pendNext      = pendSum[PEND_WIDTH-1:0];
        pendUnderflow = 1'b0;
        if (mem_readdatavalid) begin
            if (pendSum == '0) begin
                pendUnderflow = 1'b1;
            end else begin
                pendNext = pendSum[PEND_WIDTH-1:0] - PEND_WIDTH'(1);
            end
        end
    end

    // Outstanding-beat counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_beats_pending <= '0;
        end else begin
            rd_beats_pending <= pendNext;
        end
    end

    // Burst tracking over accepted AFU beats, flags malformed bursts
    always_comb begin
        stateNext     = state;
        beatsLeftNext = beatsLeft;
        burstErr      = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (afu_burstcount == '0) begin
                        burstErr = 1'b1;
                    end
                    if (afu_write && !afu_read && (afu_burstcount > BURST_CNT_WIDTH'(1))) begin
                        stateNext     = WR_BURST;
                        beatsLeftNext = afu_burstcount - BURST_CNT_WIDTH'(1);
                    end
                end
                WR_BURST: begin
                    if (afu_read) begin
                        burstErr = 1'b1;
                    end else begin
                        beatsLeftNext = beatsLeft - BURST_CNT_WIDTH'(1);
                        if (beatsLeft == BURST_CNT_WIDTH'(1)) begin
                            stateNext = IDLE;
                        end
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    // Burst FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            beatsLeft <= '0;
        end else begin
            state     <= stateNext;
            beatsLeft <= beatsLeftNext;
        end
    end

    // Sticky protocol error, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_protocol <= 1'b0;
        end else if (burstErr || pendUnderflow) begin
            err_protocol <= 1'b1;
        end
    end

    // Response path: one register stage, data held between valid beats
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            afu_readdatavalid <= 1'b0;
            afu_readdata      <= '0;
        end else begin
            afu_readdatavalid <= mem_readdatavalid;
            if (mem_readdatavalid) begin
                afu_readdata <= mem_readdata;
            end
        end
    end

endmodule

// File: tb/tb_ofs_plat_compat_avalon_mem_rd_throttle.sv
// Bench for the per-bank request/throttle stage. A queue-based model of the
// request buffer, beat budget and burst rules predicts every output each
// cycle; directed scenarios add literal expectations, then a random phase.

module tb_ofs_plat_compat_avalon_mem_rd_throttle;

    localparam int AW   = 27;
    localparam int DW   = 64;
    localparam int BW   = 7;
    localparam int MAXB = 256;
    localparam int BEW  = DW / 8;
    localparam int PW   = $clog2(MAXB + 1);

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [AW-1:0]  afu_address = '0;
    logic           afu_read = 1'b0;
    logic           afu_write = 1'b0;
    logic [BW-1:0]  afu_burstcount = '0;
    logic [DW-1:0]  afu_writedata = '0;
    logic [BEW-1:0] afu_byteenable = '0;
    logic           afu_waitrequest;
    logic [DW-1:0]  afu_readdata;
    logic           afu_readdatavalid;
    logic [AW-1:0]  mem_address;
    logic           mem_read;
    logic           mem_write;
    logic [BW-1:0]  mem_burstcount;
    logic [DW-1:0]  mem_writedata;
    logic [BEW-1:0] mem_byteenable;
    logic           mem_waitrequest = 1'b0;
    logic [DW-1:0]  mem_readdata;
    logic           mem_readdatavalid;
    logic [PW-1:0]  rd_beats_pending;
    logic           err_protocol;

    ofs_plat_compat_avalon_mem_rd_throttle #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .MAX_RD_BEATS(MAXB)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .afu_address(afu_address), .afu_read(afu_read), .afu_write(afu_write),
        .afu_burstcount(afu_burstcount), .afu_writedata(afu_writedata),
        .afu_byteenable(afu_byteenable), .afu_waitrequest(afu_waitrequest),
        .afu_readdata(afu_readdata), .afu_readdatavalid(afu_readdatavalid),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_burstcount(mem_burstcount), .mem_writedata(mem_writedata),
        .mem_byteenable(mem_byteenable), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
        .rd_beats_pending(rd_beats_pending), .err_protocol(err_protocol)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit             rd;
        bit             wr;
        logic [AW-1:0]  addr;
        logic [BW-1:0]  bc;
        logic [DW-1:0]  data;
        logic [BEW-1:0] be;
    } reqT;

    int checks = 0;
    int errors = 0;

    // model state
    reqT           mq[$];
    bit            expWait;
    int            pend;
    bit            expErr;
    bit            expRdv;
    logic [DW-1:0] expRdata;
    bit            inBurst;
    int            left;

    int issuedBeats   = 0;
    int returnedBeats = 0;
    int respGiven     = 0;
    int respAllowed   = 0;
    bit respRandom    = 0;
    int memPops       = 0;
    bit rndDone       = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model one clock
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mq.delete();
                expWait  = 1'b1;
                pend     = 0;
                expErr   = 1'b0;
                expRdv   = 1'b0;
                expRdata = '0;
                inBurst  = 1'b0;
                left     = 0;
            end
            begin : cyc
                bit  hv, ok, eRd, eWr, acc, pop;
                reqT h;
                int  sum;
                hv  = (mq.size() > 0);
                if (hv) h = mq[0];
                ok  = hv && (!h.rd || (pend + int'(h.bc) <= MAXB));
                eRd = ok && h.rd;
                eWr = ok && h.wr;
                chk("afu_waitrequest", 64'(afu_waitrequest), 64'(expWait));
                chk("mem_read", 64'(mem_read), 64'(eRd));
                chk("mem_write", 64'(mem_write), 64'(eWr));
                if (eRd || eWr) begin
                    chk("mem_address", 64'(mem_address), 64'(h.addr));
                    chk("mem_burstcount", 64'(mem_burstcount), 64'(h.bc));
                    if (eWr) begin
                        chk("mem_writedata", 64'(mem_writedata), 64'(h.data));
                        chk("mem_byteenable", 64'(mem_byteenable), 64'(h.be));
                    end
                end
                chk("rd_beats_pending", 64'(rd_beats_pending), 64'(pend));
                chk("err_protocol", 64'(err_protocol), 64'(expErr));
                chk("afu_readdatavalid", 64'(afu_readdatavalid), 64'(expRdv));
                chk("afu_readdata", 64'(afu_readdata), 64'(expRdata));
                if (reset_n) begin
                    acc = (afu_read || afu_write) && !expWait;
                    pop = (eRd || eWr) && !mem_waitrequest;
                    if ((mem_read || mem_write) && !mem_waitrequest) memPops++;
                    sum = pend;
                    if (eRd && !mem_waitrequest) begin
                        sum += int'(h.bc);
                        issuedBeats += int'(h.bc);
                    end
                    if (mem_readdatavalid) begin
                        if (sum == 0) expErr = 1'b1;
                        else sum--;
                    end
                    pend = sum;
                    if (acc) begin
                        if (!inBurst) begin
                            if (afu_burstcount == 0) expErr = 1'b1;
                            if (afu_write && !afu_read && afu_burstcount > 1) begin
                                inBurst = 1'b1;
                                left    = int'(afu_burstcount) - 1;
                            end
                        end else if (afu_read) begin
                            expErr = 1'b1;
                        end else begin
                            left--;
                            if (left == 0) inBurst = 1'b0;
                        end
                    end
                    if (pop) void'(mq.pop_front());
                    if (acc) mq.push_back('{afu_read, afu_write, afu_address, afu_burstcount,
                                            afu_writedata, afu_byteenable});
                    expWait = (mq.size() == 2);
                    expRdv  = mem_readdatavalid;
                    if (mem_readdatavalid) expRdata = mem_readdata;
                end
            end
        end
    end

    // Bank responder: returns owed read beats while the stimulus allows it
    initial begin
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_readdatavalid = 1'b0;
            if (!reset_n) begin
                returnedBeats = issuedBeats;
            end else if (respAllowed > respGiven && issuedBeats > returnedBeats &&
                         (!respRandom || $urandom_range(1, 0) == 1)) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = {$urandom(), $urandom()};
                returnedBeats++;
                respGiven++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        afu_read  = 1'b0;
        afu_write = 1'b0;
        repeat (n) tick();
    endtask

    task automatic req(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] bc);
        int budget;
        budget         = 0;
        afu_read       = rd;
        afu_write      = wr;
        afu_address    = a;
        afu_burstcount = bc;
        afu_writedata  = {$urandom(), $urandom()};
        afu_byteenable = BEW'($urandom());
        @(negedge clk);
        while (afu_waitrequest && budget < 3000) begin
            budget++;
            @(negedge clk);
        end
        if (budget >= 3000) chk("accept_timeout", 64'(afu_waitrequest), 64'(0));
        tick();
        afu_read  = 1'b0;
        afu_write = 1'b0;
    endtask

    task automatic wrBurst(input logic [AW-1:0] a, input int b);
        for (int i = 0; i < b; i++) req(1'b0, 1'b1, a + AW'(i), BW'(b));
    endtask

    task automatic doReset(input int n);
        reset_n         = 1'b0;
        afu_read        = 1'b0;
        afu_write       = 1'b0;
        mem_waitrequest = 1'b0;
        repeat (n) tick();
        reset_n = 1'b1;
    endtask

    task automatic waitPending(input int target, input string name);
        int b;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (int'(rd_beats_pending) != target && b < 2000);
        chk(name, 64'(rd_beats_pending), 64'(target));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int base;

        // 1: reset values, then waitrequest drops on the first clock after release
        repeat (5) tick();
        @(negedge clk);
        chk("rst_waitrequest", 64'(afu_waitrequest), 64'(1));
        chk("rst_readdatavalid", 64'(afu_readdatavalid), 64'(0));
        chk("rst_readdata", 64'(afu_readdata), 64'(0));
        chk("rst_mem_read", 64'(mem_read), 64'(0));
        chk("rst_mem_write", 64'(mem_write), 64'(0));
        chk("rst_pending", 64'(rd_beats_pending), 64'(0));
        chk("rst_err", 64'(err_protocol), 64'(0));
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("release_wr_before_clk", 64'(afu_waitrequest), 64'(1));
        @(negedge clk);
        chk("release_wr_first_clk", 64'(afu_waitrequest), 64'(0));
        tick();

        // 2: streaming single-beat writes
        base = memPops;
        for (int i = 0; i < 64; i++) req(1'b0, 1'b1, AW'(32'h100 + i), BW'(1));
        idle(3);
        chk("stream_pops", 64'(memPops - base), 64'(64));

        // 3: read throttle at the beat cap
        respAllowed = respGiven;
        for (int i = 0; i < 5; i++) req(1'b1, 1'b0, AW'(32'h1000 + 64 * i), BW'(64));
        idle(3);
        @(negedge clk);
        chk("thr_pending_full", 64'(rd_beats_pending), 64'(256));
        chk("thr_fifth_held", 64'(mem_read), 64'(0));
        tick();
        respAllowed = respGiven + 1;
        idle(4);
        @(negedge clk);
        chk("thr_one_back", 64'(rd_beats_pending), 64'(255));
        chk("thr_still_held", 64'(mem_read), 64'(0));
        tick();
        respAllowed = respGiven + 63;
        waitPending(192, "thr_reach_192");
        chk("thr_release_same_clk", 64'(mem_read), 64'(1));
        tick();
        respAllowed = respGiven + 1000;
        waitPending(0, "thr_drain");
        tick();

        // 4: bank backpressure during streaming writes
        base = memPops;
        fork
            begin
                for (int i = 0; i < 20; i++) req(1'b0, 1'b1, AW'(32'h200 + i), BW'(1));
            end
            begin
                repeat (3) tick();
                mem_waitrequest = 1'b1;
                repeat (4) @(negedge clk);
                chk("bp_waitrequest_high", 64'(afu_waitrequest), 64'(1));
                repeat (7) tick();
                mem_waitrequest = 1'b0;
            end
        join
        idle(3);
        chk("bp_pops", 64'(memPops - base), 64'(20));

        // 5: read inside a write burst, then burstcount 0 on SOP
        req(1'b0, 1'b1, AW'(32'h300), BW'(4));
        req(1'b0, 1'b1, AW'(32'h301), BW'(4));
        @(negedge clk);
        chk("proto_clean_burst", 64'(err_protocol), 64'(0));
        tick();
        req(1'b1, 1'b0, AW'(32'h400), BW'(1));
        idle(2);
        @(negedge clk);
        chk("proto_read_in_burst", 64'(err_protocol), 64'(1));
        tick();
        respAllowed = respGiven + 10;
        idle(6);
        @(negedge clk);
        chk("proto_sticky", 64'(err_protocol), 64'(1));
        tick();
        doReset(3);
        tick();
        req(1'b1, 1'b0, AW'(32'h500), BW'(0));
        idle(2);
        @(negedge clk);
        chk("proto_bc_zero", 64'(err_protocol), 64'(1));
        tick();

        // 6: issue and response in the same clock, then reset mid-burst
        doReset(2);
        tick();
        respAllowed = respGiven;
        req(1'b1, 1'b0, AW'(32'h600), BW'(10));
        idle(3);
        @(negedge clk);
        chk("sim_pending_10", 64'(rd_beats_pending), 64'(10));
        tick();
        mem_waitrequest = 1'b1;
        req(1'b1, 1'b0, AW'(32'h700), BW'(8));
        idle(1);
        mem_waitrequest = 1'b0;
        respAllowed = respGiven + 1;
        tick();
        @(negedge clk);
        chk("sim_pending_17", 64'(rd_beats_pending), 64'(17));
        tick();
        req(1'b0, 1'b1, AW'(32'h800), BW'(4));
        req(1'b0, 1'b1, AW'(32'h801), BW'(4));
        doReset(2);
        @(negedge clk);
        chk("midrst_pending", 64'(rd_beats_pending), 64'(0));
        tick();
        req(1'b1, 1'b0, AW'(32'h900), BW'(1));
        idle(3);
        @(negedge clk);
        chk("midrst_fsm_idle", 64'(err_protocol), 64'(0));
        tick();

        // random traffic with random backpressure and response timing
        respRandom  = 1'b1;
        respAllowed = respGiven + 1000000;
        rndDone     = 1'b0;
        fork
            begin
                for (int t = 0; t < 400; t++) begin
                    int k;
                    k = $urandom_range(9, 0);
                    if (k < 4) req(1'b1, 1'b0, AW'($urandom()), BW'($urandom_range(64, 1)));
                    else if (k < 8) wrBurst(AW'($urandom()), $urandom_range(8, 1));
                    else idle($urandom_range(4, 1));
                end
                rndDone = 1'b1;
            end
            begin
                while (!rndDone) begin
                    tick();
                    mem_waitrequest = ($urandom_range(3, 0) == 0);
                end
                mem_waitrequest = 1'b0;
            end
        join
        idle(4);
        waitPending(0, "final_drain");
        tick();
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
